dcache_wt: RTL
==============

// Module: dcache_wt
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate L1 data cache between the core's MM1/MM2 stages and memory.
//  Core drives the request from MM1; the cache returns the aligned word and hit in MM2 the following cycle.
//  Misses refill a full line from memory over a req/ack bus. hit=0 stalls the core.
// PARAMETERS
//  INDEX_BITS  6   log2(number of lines)
//  LINE_WORDS  4   32-bit words per line, power of 2, >=2
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   async active-low reset
//  re         in   1   load request (from core data_cache_re)
//  raddr      in   32  load address
//  we         in   1   store request
//  waddr      in   32  store address
//  wdata      in   32  store data, already placed on byte lanes
//  access_sz  in   3   `SZ_B / `SZ_H / `SZ_W
//  rdata      out  32  aligned word at raddr[31:2]; core shifts lanes
//  hit        out  1   1 = no outstanding op, rdata valid for last load; 0 = stall
//  mem_req    out  1   memory beat request, held until mem_ack
//  mem_we     out  1   1 = write beat
//  mem_addr   out  32  word-aligned beat address
//  mem_wdata  out  32  write data
//  mem_wstrb  out  4   byte strobes for write
//  mem_ack    in   1   beat complete; mem_rdata valid same cycle
//  mem_rdata  in   32  read beat data
// BEHAVIOUR
//  Reset: all valid bits=0, state IDLE, hit=1, rdata=0, mem_req=0, mem_we=0, mem_wstrb=0.
//  Accept: request sampled at an edge when state IDLE, or state RESP, or state CMP with hit.
//   we&re both high -> treated as store. Arrays are read synchronously at the accept edge.
//  States:
//   IDLE: hit=1.
//   CMP (cycle after accept):
//    - Load, tag match & valid -> hit=1, rdata=array word. Next state is IDLE, or CMP if a new request is accepted.
//    - Load miss -> hit=0, REFILL.
//    - Store -> hit=0, WRITE.
//   REFILL: beats i=0..LINE_WORDS-1, mem_addr = {tag,index,i,2'b00}, mem_we=0.
//    - Each ack writes the word; the next beat's req rises the cycle after the ack.
//    - After the last ack: set valid and tag, go to RESP.
//   WRITE: one beat. mem_addr=waddr&~3, mem_wdata=wdata.
//    - wstrb: B = 1<<a[1:0]; H = 3<<a[1:0] (lanes >3 dropped); W = 4'hF.
//    - On ack, if the line is valid with matching tag, merge wstrb bytes into the array (no allocate on miss). Go to RESP.
//   RESP: hit=1. rdata = requested word (load) or unchanged (store). Accepts new request.
//  While hit=0, core inputs are ignored; the core holds them, and they are accepted in RESP.
//  mem_req and its payload are stable from assertion until ack. Single outstanding beat.
//  Store to the line being refilled cannot occur (single outstanding op).
//  Reset mid-REFILL/WRITE: mem_req drops immediately, line not validated, memory model must abandon the beat.
//  Index = addr[INDEX_BITS+OFF+1 : OFF+2], OFF=log2(LINE_WORDS). Tag = remaining upper bits.
// STRUCTURE
//  defs.v: `SZ_B=3'd0, `SZ_H=3'd1, `SZ_W=3'd2, state encodings DC_IDLE/DC_CMP/DC_REFILL/DC_WRITE/DC_RESP.
//  Sub-module dcache_ram: sync-read, byte-write RAM (used for data; tag+valid in flops or a second instance).
//  Top holds FSM, beat counter, request registers, strobe gen.
// TESTING
//  1. Cold load 0x0000_1004 after reset, mem returns 0x100+i per beat (ack 2-cycle latency):
//     - expect hit=0, 4 beats at 0x1000..0x100C;
//     - RESP hit=1, rdata=0x101.
//  2. Back-to-back loads 0x1008, 0x100C after (1) -> hit=1 both cycles, rdata 0x102 then 0x103, no mem_req.
//  3. Store byte 0xAB at 0x1005, lane1 wdata=0x0000AB00:
//     - expect mem_wstrb=4'b0010, mem_addr=0x1004;
//     - then load 0x1004 -> rdata=0x0000AB01.
//  4. Store word to uncached 0x2000 then load 0x2000 -> store does not allocate; load refills (4 beats).
//  5. Conflicting index 0x1000 vs 0x1000+(4<<(INDEX_BITS+2)) -> second load misses, evicts; reload of 0x1000 misses again.
//  6. Assert rst_n=0 during beat 2 of a refill:
//     - mem_req=0 immediately, hit=1;
//     - repeat the load -> full 4-beat refill.

Source files
------------

// File: rtl/dcache_wt_pkg.sv
// Shared definitions for the write-through L1 data cache: access sizes,
// controller states and the store byte-strobe helper.
package dcache_wt_pkg;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    DC_IDLE,
    DC_CMP,
    DC_REFILL,
    DC_WRITE,
    DC_RESP
  } dc_state_t;

  // Byte lanes touched by a store; halfword lanes past byte 3 fall off the word.
  function automatic logic [3:0] byte_strobe(input logic [2:0] sz, input logic [1:0] lane);
    logic [3:0] s;
    case (sz)
      SZ_B:    s = 4'b0001 << lane;
      SZ_H:    s = 4'b0011 << lane;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dcache_wt_ram.sv
// Synchronous-read data store with per-byte write enables.
module dcache_ram
  import dcache_wt_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [3:0]           wstrb,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  // Registered read on request, byte-lane merge on write.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Loads hit in the cycle after acceptance; misses refill a whole line one
// beat at a time, stores always go to memory and update the line only if cached.
module dcache_wt
  import dcache_wt_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re,
  input  logic [31:0] raddr,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [2:0]  access_sz,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OFF    = $clog2(LINE_WORDS);
  localparam int LINES  = 2**INDEX_BITS;
  localparam int TAG_W  = 30 - INDEX_BITS - OFF;
  localparam int RAM_AW = INDEX_BITS + OFF;

  dc_state_t state, state_nx;

  logic                  req_store;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [2:0]            req_sz;
  logic [OFF-1:0]        beat;
  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tags [LINES];
  logic [31:0]           rdata_q;
  logic [31:0]           ram_rdata;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [OFF-1:0]        req_word;
  logic                  line_hit;
  logic                  cmp_hit;
  logic                  in_req;
  logic [31:0]           in_addr;
  logic                  accept;
  logic                  ack_last;
  logic [3:0]            wstrb;
  logic [RAM_AW-1:0]     ram_addr;
  logic [3:0]            ram_wstrb;
  logic [31:0]           ram_wdata;

  assign req_idx  = req_addr[INDEX_BITS+OFF+1:OFF+2];
  assign req_tag  = req_addr[31:INDEX_BITS+OFF+2];
  assign req_word = req_addr[OFF+1:2];
  assign line_hit = valid[req_idx] && (tags[req_idx] == req_tag);
  assign cmp_hit  = (state == DC_CMP) && !req_store && line_hit;
  assign in_req   = re | we;
  assign in_addr  = we ? waddr : raddr;
  assign accept   = in_req && ((state == DC_IDLE) || (state == DC_RESP) || cmp_hit);
  assign ack_last = (state == DC_REFILL) && mem_ack && (beat == OFF'(LINE_WORDS - 1));
  assign wstrb    = byte_strobe(req_sz, req_addr[1:0]);

  // The array is read at the accept edge; otherwise it points at the beat being written.
  assign ram_addr  = accept ? in_addr[RAM_AW+1:2]
                   : (state == DC_REFILL) ? {req_idx, beat} : {req_idx, req_word};
  assign ram_wstrb = ((state == DC_REFILL) && mem_ack) ? 4'hF
                   : ((state == DC_WRITE) && mem_ack && line_hit) ? wstrb : 4'h0;
  assign ram_wdata = (state == DC_REFILL) ? mem_rdata : req_wdata;

  // A CMP-stage hit shows the array word directly; every other state shows the held word.
  assign rdata = cmp_hit ? ram_rdata : rdata_q;

  dcache_ram #(.ADDR_BITS(RAM_AW)) u_data (
    .clk   (clk),
    .re    (accept),
    .addr  (ram_addr),
    .wstrb (ram_wstrb),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DC_IDLE;
    else        state <= state_nx;
  end

  // Next state and the stall indication back to the core.
  always_comb begin
    state_nx = state;
    hit      = 1'b1;
    case (state)
      DC_IDLE: if (in_req) state_nx = DC_CMP;
      DC_CMP: begin
        if (req_store) begin
          hit      = 1'b0;
          state_nx = DC_WRITE;
        end else if (line_hit) begin
          state_nx = in_req ? DC_CMP : DC_IDLE;
        end else begin
          hit      = 1'b0;
          state_nx = DC_REFILL;
        end
      end
      DC_REFILL: begin
        hit = 1'b0;
        if (ack_last) state_nx = DC_RESP;
      end
      DC_WRITE: begin
        hit = 1'b0;
        if (mem_ack) state_nx = DC_RESP;
      end
      DC_RESP: state_nx = in_req ? DC_CMP : DC_IDLE;
      default: state_nx = DC_IDLE;
    endcase
  end

  // Memory beat is a pure function of state so it drops the instant reset asserts.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (state == DC_REFILL) begin
      mem_req  = 1'b1;
      mem_addr = {req_tag, req_idx, beat, 2'b00};
    end else if (state == DC_WRITE) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {req_addr[31:2], 2'b00};
      mem_wdata = req_wdata;
      mem_wstrb = wstrb;
    end
  end

  // Capture the accepted request; a simultaneous load and store is a store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_store <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_sz    <= SZ_W;
    end else if (accept) begin
      req_store <= we;
      req_addr  <= in_addr;
      req_wdata <= wdata;
      req_sz    <= access_sz;
    end
  end

  // Refill beat counter restarts from word 0 on every miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               beat <= '0;
    else if (state == DC_CMP)                 beat <= '0;
    else if ((state == DC_REFILL) && mem_ack) beat <= beat + 1'b1;
  end

  // Held load data: latched from a CMP hit or from the matching refill beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rdata_q <= '0;
    else if (cmp_hit) rdata_q <= ram_rdata;
    else if ((state == DC_REFILL) && mem_ack && (beat == req_word)) rdata_q <= mem_rdata;
  end

  // A line becomes valid only once its final refill beat has landed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        valid <= '0;
    else if (ack_last) valid[req_idx] <= 1'b1;
  end

  // Tag store, qualified by the valid bits so it needs no reset.
  always_ff @(posedge clk) begin
    if (ack_last) tags[req_idx] <= req_tag;
  end

endmodule
